// File: rtl/scpad_rd_seq_mc_pkg.sv
// Shared types and default widths for the multi-VC scratchpad read sequencer.
// Contents:
//   rd_seq_state_t : per-VC sequencer state
//   rd_desc_t      : descriptor bundle at default widths
//   vc_width()     : index width for a given VC count (never below 1 bit)
package scpad_rd_seq_mc_pkg;

  localparam int DEF_NUM_VC      = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_LEN_W       = 8;
  localparam int DEF_MAX_OUTST   = 8;
  localparam int DEF_SCPAD_WORDS = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_seq_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_ADDR_W-1:0] stride;
  } rd_desc_t;

  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scpad_rr_arb.sv
// Round-robin arbiter with grant lock.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester request vector
//   accept     : downstream accepts the current grant
//   gnt_valid  : some request is being granted
//   gnt_idx    : index of the granted requester
// The winner is the first requester at or after the rr pointer. A grant
// offered without accept is held for the next cycle so that late-arriving
// requests cannot steal it; the pointer moves past the winner on accept.
module scpad_rr_arb
  import scpad_rd_seq_mc_pkg::*;
#(
  parameter int NUM_VC = 4,
  localparam int VC_W  = vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_VC-1:0] req,
  input  logic              accept,
  output logic              gnt_valid,
  output logic [VC_W-1:0]   gnt_idx
);

  logic [VC_W-1:0] rr_q;
  logic            lock_q;
  logic [VC_W-1:0] lock_idx_q;
  logic [VC_W-1:0] search_idx;
  logic            found;
  int              j;

  always_comb begin
    search_idx = '0;
    found      = 1'b0;
    j          = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_VC) j = j - NUM_VC;
      if (!found && req[j]) begin
        found      = 1'b1;
        search_idx = VC_W'(j);
      end
    end
    gnt_valid = |req;
    gnt_idx   = lock_q ? lock_idx_q : search_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= gnt_valid & ~accept;
      if (gnt_valid && !accept) lock_idx_q <= gnt_idx;
      if (gnt_valid && accept)
        rr_q <= (int'(gnt_idx) == NUM_VC - 1) ? '0 : VC_W'(gnt_idx + 1'b1);
    end
  end

endmodule

// File: rtl/scpad_rd_seq_mc.sv
// Multi-VC strided scratchpad read sequencer.
// Each VC accepts one descriptor (base, len, stride), its beat requests are
// round-robin arbitrated onto one read port under a global outstanding
// credit, and in-order VC-tagged responses are counted to a done pulse.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   desc_valid/desc_ready         : per-VC descriptor handshake
//   desc_addr/desc_len/desc_stride: packed per-VC descriptor fields
//   req_valid/req_ready           : read request handshake
//   req_addr, req_vc              : request address and owning VC
//   rdata_valid, rdata_vc         : returned beat and its VC tag
//   done                          : one-cycle per-VC completion pulse
//   busy                          : VC not idle
//   err (SCPAD_RD_SEQ_BOUNDS_EN)  : one-cycle out-of-bounds descriptor reject
// Build option: define SCPAD_RD_SEQ_BOUNDS_EN to reject descriptors whose last
// beat lands at or above SCPAD_WORDS; otherwise addresses wrap silently.
//
// state | meaning
// IDLE  | ready for a descriptor
// ISSUE | beats still to be requested
// DRAIN | all beats requested, waiting for responses
// DONE  | done pulse, back to IDLE next cycle
module scpad_rd_seq_mc
  import scpad_rd_seq_mc_pkg::*;
#(
  parameter int NUM_VC      = DEF_NUM_VC,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int MAX_OUTST   = DEF_MAX_OUTST,
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
  parameter int SCPAD_WORDS = DEF_SCPAD_WORDS,
`endif
  localparam int VC_W       = vc_width(NUM_VC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VC-1:0]        desc_valid,
  output logic [NUM_VC-1:0]        desc_ready,
  input  logic [NUM_VC*ADDR_W-1:0] desc_addr,
  input  logic [NUM_VC*LEN_W-1:0]  desc_len,
  input  logic [NUM_VC*ADDR_W-1:0] desc_stride,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [ADDR_W-1:0]        req_addr,
  output logic [VC_W-1:0]          req_vc,
  input  logic                     rdata_valid,
  input  logic [VC_W-1:0]          rdata_vc,
  output logic [NUM_VC-1:0]        done,
  output logic [NUM_VC-1:0]        busy
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
  ,
  output logic [NUM_VC-1:0]        err
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int BND_W = ADDR_W + LEN_W + 1;

  rd_seq_state_t     st_q     [NUM_VC];
  rd_seq_state_t     st_d     [NUM_VC];
  logic [ADDR_W-1:0] addr_q   [NUM_VC];
  logic [ADDR_W-1:0] addr_d   [NUM_VC];
  logic [ADDR_W-1:0] stride_q [NUM_VC];
  logic [ADDR_W-1:0] stride_d [NUM_VC];
  logic [LEN_W-1:0]  len_q    [NUM_VC];
  logic [LEN_W-1:0]  len_d    [NUM_VC];
  logic [LEN_W-1:0]  iss_q    [NUM_VC];
  logic [LEN_W-1:0]  iss_d    [NUM_VC];
  logic [LEN_W-1:0]  ret_q    [NUM_VC];
  logic [LEN_W-1:0]  ret_d    [NUM_VC];
  logic [OUT_W-1:0]  outst_q, outst_d;

  logic [NUM_VC-1:0] elig, arb_req, rsp_hit, grant_oh;
  logic              credit_ok, hs, gnt_valid;
  logic [VC_W-1:0]   gnt_idx;

`ifdef SCPAD_RD_SEQ_BOUNDS_EN
  logic [NUM_VC-1:0] err_q, err_d;
  logic [BND_W-1:0]  last_addr;
  assign err = err_q;
`endif

  // A response only counts for a VC that still has a beat in flight, which
  // keeps the outstanding counter equal to the sum of in-flight beats.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      elig[v]    = (st_q[v] == ISSUE) && (iss_q[v] != len_q[v]);
      rsp_hit[v] = rdata_valid && (rdata_vc == VC_W'(v)) &&
                   ((st_q[v] == ISSUE) || (st_q[v] == DRAIN)) &&
                   (ret_q[v] != iss_q[v]);
      grant_oh[v] = hs && (gnt_idx == VC_W'(v));
    end
  end

  assign credit_ok = (outst_q < OUT_W'(MAX_OUTST));
  assign arb_req   = elig & {NUM_VC{credit_ok}};

  scpad_rr_arb #(.NUM_VC(NUM_VC)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .accept    (req_ready),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign req_valid = gnt_valid;
  assign req_vc    = gnt_idx;
  assign req_addr  = addr_q[gnt_idx];
  assign hs        = gnt_valid & req_ready;

  assign outst_d = outst_q + OUT_W'(hs) - OUT_W'(|rsp_hit);

  always_comb begin
    desc_ready = '0;
    busy       = '0;
    done       = '0;
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
    err_d      = '0;
    last_addr  = '0;
`endif
    for (int v = 0; v < NUM_VC; v++) begin
      st_d[v]     = st_q[v];
      addr_d[v]   = addr_q[v];
      stride_d[v] = stride_q[v];
      len_d[v]    = len_q[v];
      iss_d[v]    = iss_q[v];
      ret_d[v]    = ret_q[v];
      busy[v]     = (st_q[v] != IDLE);
      case (st_q[v])
        IDLE: begin
          desc_ready[v] = 1'b1;
          if (desc_valid[v]) begin
            addr_d[v]   = desc_addr[v*ADDR_W +: ADDR_W];
            stride_d[v] = desc_stride[v*ADDR_W +: ADDR_W];
            len_d[v]    = desc_len[v*LEN_W +: LEN_W];
            iss_d[v]    = '0;
            ret_d[v]    = '0;
            if (desc_len[v*LEN_W +: LEN_W] == '0) begin
              st_d[v] = DONE;
            end else begin
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
              // Full-precision last beat address, so wrap cannot hide an overrun.
              last_addr = BND_W'(desc_addr[v*ADDR_W +: ADDR_W]) +
                          BND_W'(desc_len[v*LEN_W +: LEN_W] - LEN_W'(1)) *
                          BND_W'(desc_stride[v*ADDR_W +: ADDR_W]);
              if (last_addr >= BND_W'(SCPAD_WORDS)) begin
                err_d[v] = 1'b1;
                st_d[v]  = IDLE;
              end else begin
                st_d[v] = ISSUE;
              end
`else
              st_d[v] = ISSUE;
`endif
            end
          end
        end
        ISSUE: begin
          if (grant_oh[v]) begin
            iss_d[v]  = iss_q[v] + LEN_W'(1);
            addr_d[v] = addr_q[v] + stride_q[v];
            if (iss_q[v] + LEN_W'(1) == len_q[v]) st_d[v] = DRAIN;
          end
          if (rsp_hit[v]) ret_d[v] = ret_q[v] + LEN_W'(1);
        end
        DRAIN: begin
          // Move straight to DONE on the final beat so the pulse lands one
          // cycle after that beat.
          if (rsp_hit[v]) begin
            ret_d[v] = ret_q[v] + LEN_W'(1);
            if (ret_q[v] + LEN_W'(1) == len_q[v]) st_d[v] = DONE;
          end
        end
        DONE: begin
          done[v] = 1'b1;
          st_d[v] = IDLE;
        end
        default: st_d[v] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        st_q[v]     <= IDLE;
        addr_q[v]   <= '0;
        stride_q[v] <= '0;
        len_q[v]    <= '0;
        iss_q[v]    <= '0;
        ret_q[v]    <= '0;
      end
      outst_q <= '0;
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
      err_q   <= '0;
`endif
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        st_q[v]     <= st_d[v];
        addr_q[v]   <= addr_d[v];
        stride_q[v] <= stride_d[v];
        len_q[v]    <= len_d[v];
        iss_q[v]    <= iss_d[v];
        ret_q[v]    <= ret_d[v];
      end
      outst_q <= outst_d;
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_scpad_rd_seq_mc.sv
// Self-checking bench for scpad_rd_seq_mc: directed scenarios plus a random
// phase, with a per-cycle reference model written in terms of beat counts.
module tb_scpad_rd_seq_mc;

  localparam int NV = 4;
  localparam int AW = 16;
  localparam int LW = 8;
  localparam int MO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NV-1:0]   desc_valid, desc_ready, done, busy;
  logic [NV*AW-1:0] desc_addr, desc_stride;
  logic [NV*LW-1:0] desc_len;
  logic            req_valid, req_ready;
  logic [AW-1:0]   req_addr;
  logic [1:0]      req_vc;
  logic            rdata_valid;
  logic [1:0]      rdata_vc;
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
  logic [NV-1:0]   err;
`endif

  scpad_rd_seq_mc dut (
    .clk         (clk),
    .rst         (rst),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_addr   (desc_addr),
    .desc_len    (desc_len),
    .desc_stride (desc_stride),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_vc      (req_vc),
    .rdata_valid (rdata_valid),
    .rdata_vc    (rdata_vc),
    .done        (done),
    .busy        (busy)
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // scratchpad response queue and logs
  typedef struct {int vc; int due;} rsp_t;
  rsp_t rq[$];
  int   hs_addr[$];
  int   hs_vc[$];
  int   hs_t[$];
  int   done_cnt[NV];
  int   ncyc = 0;
  bit   rsp_en = 1'b1;
  int   rsp_lat = 3;
  int   t_desc = 0;

  // reference model: phase 0 idle, 1 active, 2 done pulse
  int m_ph[NV], m_base[NV], m_len[NV], m_str[NV], m_iss[NV], m_ret[NV];
  bit m_err[NV];
  int m_out, m_rr, m_lock;
  bit m_on = 1'b0;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ph[v] = 0; m_iss[v] = 0; m_ret[v] = 0; m_err[v] = 1'b0;
    end
    m_out = 0; m_rr = 0; m_lock = -1;
  endfunction

  function automatic void model_step();
    bit [NV-1:0] el;
    bit ev, hs;
    int w, j;
    longint last;
    w = -1;
    for (int v = 0; v < NV; v++) el[v] = (m_ph[v] == 1) && (m_iss[v] < m_len[v]);
    ev = (el != '0) && (m_out < MO);
    if (ev) begin
      if (m_lock >= 0) w = m_lock;
      else
        for (int i = 0; i < NV; i++) begin
          j = (m_rr + i) % NV;
          if (el[j] && w < 0) w = j;
        end
    end
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("desc_ready[%0d]", v), desc_ready[v], m_ph[v] == 0);
      chk($sformatf("busy[%0d]", v), busy[v], m_ph[v] != 0);
      chk($sformatf("done[%0d]", v), done[v], m_ph[v] == 2);
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
      chk($sformatf("err[%0d]", v), err[v], m_err[v]);
`endif
    end
    chk("req_valid", req_valid, ev);
    if (ev && w >= 0) begin
      chk("req_vc", req_vc, w);
      chk("req_addr", req_addr, (m_base[w] + m_iss[w] * m_str[w]) & 'hFFFF);
    end
    hs = ev && req_ready;
    for (int v = 0; v < NV; v++) begin
      m_err[v] = 1'b0;
      case (m_ph[v])
        2: m_ph[v] = 0;
        0: if (desc_valid[v]) begin
          m_base[v] = int'(desc_addr[v*AW +: AW]);
          m_len[v]  = int'(desc_len[v*LW +: LW]);
          m_str[v]  = int'(desc_stride[v*AW +: AW]);
          m_iss[v]  = 0;
          m_ret[v]  = 0;
          last = longint'(m_base[v]) + longint'(m_len[v] - 1) * longint'(m_str[v]);
          if (m_len[v] == 0) m_ph[v] = 2;
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
          else if (last >= 4096) m_err[v] = 1'b1;
`endif
          else m_ph[v] = 1;
        end
        1: if (rdata_valid && int'(rdata_vc) == v && m_ret[v] < m_iss[v]) begin
          m_ret[v]++;
          m_out--;
          if (m_ret[v] == m_len[v]) m_ph[v] = 2;
        end
        default: ;
      endcase
    end
    if (hs) begin
      m_iss[w]++;
      m_out++;
      m_rr = (w + 1) % NV;
    end
    m_lock = (ev && !req_ready) ? w : -1;
  endfunction

  // compare/monitor process, one pass per cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst === 1'b1) begin
        model_reset();
        m_on = 1'b1;
      end else if (m_on) begin
        if (req_valid && req_ready) begin
          hs_addr.push_back(int'(req_addr));
          hs_vc.push_back(int'(req_vc));
          hs_t.push_back(ncyc);
          rq.push_back('{vc: int'(req_vc), due: ncyc + rsp_lat});
        end
        for (int v = 0; v < NV; v++) if (done[v]) done_cnt[v]++;
        model_step();
      end
    end
  end

  // in-order scratchpad responder
  initial begin
    rdata_valid = 1'b0;
    rdata_vc    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_en && rq.size() > 0 && rq[0].due <= ncyc + 1) begin
        rdata_valid = 1'b1;
        rdata_vc    = 2'(rq[0].vc);
        void'(rq.pop_front());
      end else begin
        rdata_valid = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    hs_addr.delete(); hs_vc.delete(); hs_t.delete();
    for (int v = 0; v < NV; v++) done_cnt[v] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    desc_valid = '0;
    @(negedge clk);
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_fields(int v, int a, int l, int s);
    desc_addr[v*AW +: AW]   = AW'(a);
    desc_len[v*LW +: LW]    = LW'(l);
    desc_stride[v*AW +: AW] = AW'(s);
  endtask

  // called just after a rising edge; the descriptor is taken at the next one
  task automatic send_desc(int v, int a, int l, int s);
    set_fields(v, a, l, s);
    desc_valid[v] = 1'b1;
    @(negedge clk); #1;
    t_desc = ncyc;
    @(posedge clk); #1;
    desc_valid = '0;
  endtask

  task automatic wait_quiet(int maxc, string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (busy == '0 && rq.size() == 0 && !rdata_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: still busy=0x%0h after %0d cycles, want idle", nm, busy, maxc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    desc_valid = '0; desc_addr = '0; desc_len = '0; desc_stride = '0;
    req_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // reset state
    @(negedge clk); #1;
    chk("rst busy", busy, 0);
    chk("rst desc_ready", desc_ready, 'hF);
    chk("rst req_valid", req_valid, 0);
    chk("rst done", done, 0);
    @(posedge clk); #1;

    // single VC strided burst
    req_ready = 1'b1; rsp_lat = 3; rsp_en = 1'b1;
    send_desc(0, 'h0100, 4, 2);
    wait_quiet(60, "burst");
    chk("burst count", hs_addr.size(), 4);
    if (hs_addr.size() == 4) begin
      chk("burst a0", hs_addr[0], 'h0100);
      chk("burst a1", hs_addr[1], 'h0102);
      chk("burst a2", hs_addr[2], 'h0104);
      chk("burst a3", hs_addr[3], 'h0106);
      chk("burst latency", hs_t[0], t_desc + 1);
      chk("burst back-to-back", hs_t[3], hs_t[0] + 3);
    end
    chk("burst done count", done_cnt[0], 1);

    // four VCs at once
    do_reset();
    req_ready = 1'b1;
    for (int v = 0; v < NV; v++) begin
      set_fields(v, 'h1000 * (v + 1), 2, 1);
      desc_valid[v] = 1'b1;
    end
    @(posedge clk); #1;
    desc_valid = '0;
    wait_quiet(60, "allvc");
    chk("allvc count", hs_vc.size(), 8);
    if (hs_vc.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("allvc order %0d", i), hs_vc[i], i % 4);
    for (int v = 0; v < NV; v++) chk($sformatf("allvc done %0d", v), done_cnt[v], 1);

    // credit limit
    do_reset();
    req_ready = 1'b1; rsp_en = 1'b0;
    send_desc(0, 'h0300, 12, 1);
    repeat (15) @(negedge clk);
    #1;
    chk("credit stop count", hs_addr.size(), 8);
    chk("credit req_valid", req_valid, 0);
    rsp_en = 1'b1;
    @(negedge clk);
    rsp_en = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("credit one more", hs_addr.size(), 9);
    rsp_en = 1'b1;
    wait_quiet(80, "credit");
    chk("credit total", hs_addr.size(), 12);
    chk("credit done", done_cnt[0], 1);

    // grant lock during stall, rr pointer parked at VC1 beforehand
    do_reset();
    req_ready = 1'b1;
    send_desc(0, 'h0050, 1, 1);
    wait_quiet(40, "prestall");
    clear_logs();
    req_ready = 1'b0;
    send_desc(0, 'h0200, 4, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        set_fields(1, 'h0400, 2, 1);
        desc_valid[1] = 1'b1;
      end
      @(negedge clk); #1;
      chk("stall valid", req_valid, 1);
      chk("stall vc", req_vc, 0);
      chk("stall addr", req_addr, 'h0200);
      @(posedge clk); #1;
      desc_valid = '0;
    end
    req_ready = 1'b1;
    wait_quiet(60, "stall");
    chk("stall hs count", hs_vc.size(), 6);
    if (hs_vc.size() >= 2) begin
      chk("stall first addr", hs_addr[0], 'h0200);
      chk("stall second vc", hs_vc[1], 1);
    end

    // zero-length descriptor
    clear_logs();
    send_desc(2, 'h0010, 0, 1);
    @(negedge clk); #1;
    chk("len0 done", done[2], 1);
    chk("len0 req_valid", req_valid, 0);
    @(negedge clk); #1;
    chk("len0 done gone", done[2], 0);
    chk("len0 ready back", desc_ready[2], 1);
    chk("len0 no reqs", hs_addr.size(), 0);
    @(posedge clk); #1;

`ifdef SCPAD_RD_SEQ_BOUNDS_EN
    // out-of-bounds descriptor
    clear_logs();
    send_desc(0, 4094, 4, 1);
    @(negedge clk); #1;
    chk("bounds err", err[0], 1);
    wait_quiet(20, "bounds");
    chk("bounds no reqs", hs_addr.size(), 0);
    chk("bounds no done", done_cnt[0], 0);
`else
    // silent address wrap
    clear_logs();
    send_desc(0, 'hFFFE, 3, 1);
    wait_quiet(40, "wrap");
    chk("wrap count", hs_addr.size(), 3);
    if (hs_addr.size() == 3) begin
      chk("wrap a0", hs_addr[0], 'hFFFE);
      chk("wrap a1", hs_addr[1], 'hFFFF);
      chk("wrap a2", hs_addr[2], 'h0000);
    end
`endif

    // reset with beats in flight, then a stale response
    do_reset();
    req_ready = 1'b1; rsp_en = 1'b0;
    send_desc(1, 'h0700, 8, 1);
    for (int i = 0; i < 20; i++) begin
      if (hs_addr.size() >= 3) break;
      @(posedge clk); #1;
    end
    req_ready = 1'b0;
    chk("midrst issued", hs_addr.size(), 3);
    do_reset();
    @(negedge clk); #1;
    chk("midrst busy", busy, 0);
    chk("midrst desc_ready", desc_ready, 'hF);
    rq.push_back('{vc: 1, due: 0});
    rsp_en = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("stale done", done_cnt[1], 0);
    chk("stale busy", busy, 0);
    @(posedge clk); #1;

    // random traffic, checked by the model every cycle
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < NV; v++) begin
        desc_valid[v] = ($urandom_range(0, 2) == 0);
`ifdef SCPAD_RD_SEQ_BOUNDS_EN
        set_fields(v, $urandom_range(0, 4200), $urandom_range(0, 6), $urandom_range(0, 16));
`else
        set_fields(v, $urandom_range(0, 'hFFFF), $urandom_range(0, 6), $urandom_range(0, 16));
`endif
      end
      req_ready = ($urandom_range(0, 3) != 0);
      rsp_lat = $urandom_range(1, 6);
      @(posedge clk); #1;
    end
    desc_valid = '0;
    req_ready = 1'b1;
    wait_quiet(500, "random drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
